// File: rtl/pipeline_pkg.sv
// Shared pipeline encodings: opcodes, functs, ALU operations and the ID/EX control bundle.
// Execute imports the same control widths so both stages agree on the bundle layout.
package pipeline_pkg;

  localparam int XLEN     = 32;
  localparam int NREGS    = 32;
  localparam int REG_W    = 5;
  localparam int ALU_OP_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4
  } alu_op_e;

  typedef struct packed {
    alu_op_e          alu_op;
    logic             alu_src_imm;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic [REG_W-1:0] wreg;
  } ctrl_t;

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/decode_if.sv
// Decode-stage bus: fetch pair and redirect/stall, writeback and EX/MEM taps, ID/EX bundle.
// slave is the decode side; master is whoever drives fetch/EX/WB toward decode.
interface decode_if;
  import pipeline_pkg::*;

  logic [XLEN-1:0]     pc_in;
  logic [XLEN-1:0]     instr_in;
  logic                stall_out;
  logic                jump_out;
  logic [XLEN-1:0]     offset_out;

  logic                wb_we;
  logic [REG_W-1:0]    wb_rd;
  logic [XLEN-1:0]     wb_data;

  logic [REG_W-1:0]    exm_rd;
  logic                exm_reg_write;
  logic                exm_mem_read;
  logic [XLEN-1:0]     exm_data;

  logic                idex_valid;
  logic [XLEN-1:0]     idex_pc;
  logic [XLEN-1:0]     idex_rs_val;
  logic [XLEN-1:0]     idex_rt_val;
  logic [XLEN-1:0]     idex_imm;
  logic [REG_W-1:0]    idex_rs;
  logic [REG_W-1:0]    idex_rt;
  logic [REG_W-1:0]    idex_wreg;
  logic [ALU_OP_W-1:0] idex_alu_op;
  logic                idex_alu_src_imm;
  logic                idex_mem_read;
  logic                idex_mem_write;
  logic                idex_reg_write;

  modport master (
    output pc_in, instr_in, wb_we, wb_rd, wb_data,
           exm_rd, exm_reg_write, exm_mem_read, exm_data,
    input  stall_out, jump_out, offset_out,
           idex_valid, idex_pc, idex_rs_val, idex_rt_val, idex_imm,
           idex_rs, idex_rt, idex_wreg, idex_alu_op,
           idex_alu_src_imm, idex_mem_read, idex_mem_write, idex_reg_write
  );

  modport slave (
    input  pc_in, instr_in, wb_we, wb_rd, wb_data,
           exm_rd, exm_reg_write, exm_mem_read, exm_data,
    output stall_out, jump_out, offset_out,
           idex_valid, idex_pc, idex_rs_val, idex_rt_val, idex_imm,
           idex_rs, idex_rt, idex_wreg, idex_alu_op,
           idex_alu_src_imm, idex_mem_read, idex_mem_write, idex_reg_write
  );

endinterface

// File: rtl/decode_regfile.sv
// 32x32 register file: two combinational read ports with write-through bypass, r0 reads zero.
// One write port committed on posedge; asynchronous active-high reset clears every entry.
module decode_regfile
  import pipeline_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [REG_W-1:0] i_wa,
  input  logic [XLEN-1:0]  i_wd,
  input  logic [REG_W-1:0] i_ra1,
  input  logic [REG_W-1:0] i_ra2,
  output logic [XLEN-1:0]  o_rd1,
  output logic [XLEN-1:0]  o_rd2
);

  logic [XLEN-1:0] r_mem [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_we && i_wa != '0) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  // Writeback lands in the same cycle decode reads, so the write data is bypassed.
  function automatic logic [XLEN-1:0] rd_port(input logic [REG_W-1:0] a);
    if (a == '0)                return '0;
    else if (i_we && i_wa == a) return i_wd;
    else                        return r_mem[a];
  endfunction

  assign o_rd1 = rd_port(i_ra1);
  assign o_rd2 = rd_port(i_ra2);

endmodule

// File: rtl/decode.sv
// Decode stage: regfile read, control decode, hazard stall, branch/jump resolution; ID/EX 1 cycle.
// stall_out holds fetch and injects a bubble; DECODE_BRANCH_FWD_EN forwards EX/MEM ALU results to branches.
module decode
  import pipeline_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  decode_if.slave bus
);

`ifdef DECODE_BRANCH_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic [5:0]       w_op, w_funct;
  logic [REG_W-1:0] w_rs, w_rt, w_rd;
  logic [15:0]      w_imm16;
  logic [25:0]      w_target;
  logic [XLEN-1:0]  w_rs_val, w_rt_val, w_imm, w_cmp_a, w_cmp_b;
  logic [XLEN-1:0]  w_pc4, w_jdest, w_offset;
  logic             w_use_rs, w_use_rt, w_is_br, w_is_j;
  logic             w_exm_rs, w_exm_rt, w_load_use, w_br_idex, w_br_exm_ld, w_br_exm_alu;
  logic             w_stall, w_taken, w_jump;
  ctrl_t            w_ctrl;

  logic             r_valid;
  logic [XLEN-1:0]  r_pc, r_rs_val, r_rt_val, r_imm;
  logic [REG_W-1:0] r_rs, r_rt;
  ctrl_t            r_ctrl;

  assign w_op     = bus.instr_in[31:26];
  assign w_rs     = bus.instr_in[25:21];
  assign w_rt     = bus.instr_in[20:16];
  assign w_rd     = bus.instr_in[15:11];
  assign w_imm16  = bus.instr_in[15:0];
  assign w_funct  = bus.instr_in[5:0];
  assign w_target = bus.instr_in[25:0];
  assign w_imm    = sext16(w_imm16);

  decode_regfile u_regfile (
    .clk   (clk),
    .rst   (rst),
    .i_we  (bus.wb_we),
    .i_wa  (bus.wb_rd),
    .i_wd  (bus.wb_data),
    .i_ra1 (w_rs),
    .i_ra2 (w_rt),
    .o_rd1 (w_rs_val),
    .o_rd2 (w_rt_val)
  );

  always_comb begin
    w_ctrl   = '0;
    w_use_rt = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_use_rt         = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.wreg      = w_rd;
        case (w_funct)
          FN_ADD:  w_ctrl.alu_op = ALU_ADD;
          FN_SUB:  w_ctrl.alu_op = ALU_SUB;
          FN_AND:  w_ctrl.alu_op = ALU_AND;
          FN_OR:   w_ctrl.alu_op = ALU_OR;
          FN_SLT:  w_ctrl.alu_op = ALU_SLT;
          default: w_ctrl        = '0;
        endcase
      end
      OP_ADDI: begin
        w_ctrl.alu_src_imm = 1'b1;
        w_ctrl.reg_write   = 1'b1;
        w_ctrl.wreg        = w_rt;
      end
      OP_LW: begin
        w_ctrl.alu_src_imm = 1'b1;
        w_ctrl.mem_read    = 1'b1;
        w_ctrl.reg_write   = 1'b1;
        w_ctrl.wreg        = w_rt;
      end
      OP_SW: begin
        w_use_rt           = 1'b1;
        w_ctrl.alu_src_imm = 1'b1;
        w_ctrl.mem_write   = 1'b1;
      end
      OP_BEQ, OP_BNE: w_use_rt = 1'b1;
      default: ;
    endcase
  end

  assign w_use_rs = (w_op != OP_J);
  assign w_is_br  = (w_op == OP_BEQ) || (w_op == OP_BNE);
  assign w_is_j   = (w_op == OP_J);

  assign w_load_use = r_valid && r_ctrl.mem_read && r_ctrl.wreg != '0 &&
                      ((w_use_rs && r_ctrl.wreg == w_rs) || (w_use_rt && r_ctrl.wreg == w_rt));
  assign w_br_idex  = w_is_br && r_ctrl.reg_write && r_ctrl.wreg != '0 &&
                      (r_ctrl.wreg == w_rs || r_ctrl.wreg == w_rt);

  assign w_exm_rs     = bus.exm_reg_write && bus.exm_rd != '0 && bus.exm_rd == w_rs;
  assign w_exm_rt     = bus.exm_reg_write && bus.exm_rd != '0 && bus.exm_rd == w_rt;
  assign w_br_exm_ld  = w_is_br && bus.exm_mem_read && (w_exm_rs || w_exm_rt);
  assign w_br_exm_alu = w_is_br && !bus.exm_mem_read && (w_exm_rs || w_exm_rt) && !FWD_EN;
  assign w_stall      = w_load_use || w_br_idex || w_br_exm_ld || w_br_exm_alu;

  // Only the branch comparator sees forwarded data; execute does its own forwarding.
  assign w_cmp_a = (FWD_EN && w_exm_rs && !bus.exm_mem_read) ? bus.exm_data : w_rs_val;
  assign w_cmp_b = (FWD_EN && w_exm_rt && !bus.exm_mem_read) ? bus.exm_data : w_rt_val;
  assign w_taken = ((w_op == OP_BEQ) && (w_cmp_a == w_cmp_b)) ||
                   ((w_op == OP_BNE) && (w_cmp_a != w_cmp_b));
  assign w_jump  = (w_is_j || w_taken) && !w_stall;

  assign w_pc4   = bus.pc_in + 32'd4;
  assign w_jdest = {w_pc4[31:28], w_target, 2'b00};

  always_comb begin
    w_offset = '0;
    if (w_jump) w_offset = w_is_j ? (w_jdest - w_pc4) : (w_imm << 2);
  end

  assign bus.stall_out  = w_stall;
  assign bus.jump_out   = w_jump;
  assign bus.offset_out = w_offset;

  always_ff @(posedge clk or posedge rst) begin
    if (rst || w_stall) begin
      r_valid  <= 1'b0;
      r_pc     <= '0;
      r_rs_val <= '0;
      r_rt_val <= '0;
      r_imm    <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_ctrl   <= '0;
    end else begin
      r_valid  <= 1'b1;
      r_pc     <= bus.pc_in;
      r_rs_val <= w_rs_val;
      r_rt_val <= w_rt_val;
      r_imm    <= w_imm;
      r_rs     <= w_rs;
      r_rt     <= w_rt;
      r_ctrl   <= w_ctrl;
    end
  end

  assign bus.idex_valid       = r_valid;
  assign bus.idex_pc          = r_pc;
  assign bus.idex_rs_val      = r_rs_val;
  assign bus.idex_rt_val      = r_rt_val;
  assign bus.idex_imm         = r_imm;
  assign bus.idex_rs          = r_rs;
  assign bus.idex_rt          = r_rt;
  assign bus.idex_wreg        = r_ctrl.wreg;
  assign bus.idex_alu_op      = r_ctrl.alu_op;
  assign bus.idex_alu_src_imm = r_ctrl.alu_src_imm;
  assign bus.idex_mem_read    = r_ctrl.mem_read;
  assign bus.idex_mem_write   = r_ctrl.mem_write;
  assign bus.idex_reg_write   = r_ctrl.reg_write;

endmodule

// File: tb/tb_decode.sv
// Scoreboarded bench for decode: directed vectors push expected comb/ID-EX results, a negedge monitor checks them.
module tb_decode;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_if bus();

  decode dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        full;
    logic        v;
    logic [31:0] pc, rsv, rtv, imm;
    logic [4:0]  rs, rt, wreg;
    logic [3:0]  op;
    logic        si, mr, mw, rw;
    int          due;
  } exp_idex_t;

  typedef struct {
    logic        stall, jump;
    logic [31:0] off;
    int          due;
  } exp_comb_t;

  exp_idex_t q_idex[$];
  exp_comb_t q_comb[$];
  exp_idex_t m_ei;
  exp_comb_t m_ec;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic        p_wb_we, p_exm_rw, p_exm_mr;
  logic [4:0]  p_wb_rd, p_exm_rd;
  logic [31:0] p_wb_data, p_exm_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rt_(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] it_(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic exp_idex_t fe(input logic [31:0] pc, rsv, rtv, imm,
                                   input logic [4:0] rs, rt, wreg, input logic [3:0] op,
                                   input logic si, mr, mw, rw);
    exp_idex_t e;
    e.full = 1'b1; e.v = 1'b1; e.pc = pc; e.rsv = rsv; e.rtv = rtv; e.imm = imm;
    e.rs = rs; e.rt = rt; e.wreg = wreg; e.op = op;
    e.si = si; e.mr = mr; e.mw = mw; e.rw = rw; e.due = 0;
    return e;
  endfunction

  // NOP: valid with every control bit clear; data fields are not constrained.
  function automatic exp_idex_t nop_e();
    exp_idex_t e;
    e = fe(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    e.full = 1'b0;
    return e;
  endfunction

  function automatic exp_idex_t bub_e();
    exp_idex_t e;
    e = fe(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    e.v = 1'b0;
    return e;
  endfunction

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    p_wb_we = 1'b1; p_wb_rd = rd; p_wb_data = d;
  endtask

  task automatic exm(input logic [4:0] rd, input logic mr, input logic [31:0] d);
    p_exm_rw = 1'b1; p_exm_rd = rd; p_exm_mr = mr; p_exm_data = d;
  endtask

  task automatic step(input logic [31:0] pc, instr, input logic es, ej,
                      input logic [31:0] eo, input exp_idex_t ei);
    exp_comb_t ec;
    @(posedge clk); #1;
    bus.pc_in = pc;            bus.instr_in = instr;
    bus.wb_we = p_wb_we;       bus.wb_rd = p_wb_rd;   bus.wb_data = p_wb_data;
    bus.exm_reg_write = p_exm_rw; bus.exm_rd = p_exm_rd;
    bus.exm_mem_read = p_exm_mr;  bus.exm_data = p_exm_data;
    p_wb_we = 1'b0; p_wb_rd = '0; p_wb_data = '0;
    p_exm_rw = 1'b0; p_exm_rd = '0; p_exm_mr = 1'b0; p_exm_data = '0;
    ec.stall = es; ec.jump = ej; ec.off = eo; ec.due = cyc;
    q_comb.push_back(ec);
    ei.due = cyc + 1;
    q_idex.push_back(ei);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      while (q_comb.size() > 0 && q_comb[0].due <= cyc) begin
        m_ec = q_comb.pop_front();
        if (m_ec.due < cyc) chk("comb_stale", 32'(m_ec.due), 32'(cyc));
        else begin
          chk("stall_out", 32'(bus.stall_out), 32'(m_ec.stall));
          chk("jump_out", 32'(bus.jump_out), 32'(m_ec.jump));
          chk("offset_out", bus.offset_out, m_ec.off);
        end
      end
      while (q_idex.size() > 0 && q_idex[0].due <= cyc) begin
        m_ei = q_idex.pop_front();
        if (m_ei.due < cyc) chk("idex_stale", 32'(m_ei.due), 32'(cyc));
        else begin
          chk("idex_valid", 32'(bus.idex_valid), 32'(m_ei.v));
          chk("idex_alu_op", 32'(bus.idex_alu_op), 32'(m_ei.op));
          chk("idex_alu_src_imm", 32'(bus.idex_alu_src_imm), 32'(m_ei.si));
          chk("idex_mem_read", 32'(bus.idex_mem_read), 32'(m_ei.mr));
          chk("idex_mem_write", 32'(bus.idex_mem_write), 32'(m_ei.mw));
          chk("idex_reg_write", 32'(bus.idex_reg_write), 32'(m_ei.rw));
          chk("idex_wreg", 32'(bus.idex_wreg), 32'(m_ei.wreg));
          if (m_ei.full) begin
            chk("idex_pc", bus.idex_pc, m_ei.pc);
            chk("idex_rs_val", bus.idex_rs_val, m_ei.rsv);
            chk("idex_rt_val", bus.idex_rt_val, m_ei.rtv);
            chk("idex_imm", bus.idex_imm, m_ei.imm);
            chk("idex_rs", 32'(bus.idex_rs), 32'(m_ei.rs));
            chk("idex_rt", 32'(bus.idex_rt), 32'(m_ei.rt));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time budget");
    $fatal(1);
  end

  initial begin
    bus.pc_in = '0; bus.instr_in = '0;
    bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.exm_reg_write = 1'b0; bus.exm_rd = '0; bus.exm_mem_read = 1'b0; bus.exm_data = '0;
    p_wb_we = 1'b0; p_wb_rd = '0; p_wb_data = '0;
    p_exm_rw = 1'b0; p_exm_rd = '0; p_exm_mr = 1'b0; p_exm_data = '0;

    #2;
    chk("rst_idex_valid", 32'(bus.idex_valid), 32'h0);
    chk("rst_stall_out", 32'(bus.stall_out), 32'h0);
    chk("rst_jump_out", 32'(bus.jump_out), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // r1 = 5, then addi r2,r1,3
    wb(5'd1, 32'd5);
    step(32'h0, 32'h0, 1'b0, 1'b0, 32'h0, nop_e());
    step(32'h4, 32'h20220003, 1'b0, 1'b0, 32'h0,
         fe(32'h4, 32'd5, 32'd0, 32'd3, 5'd1, 5'd2, 5'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1));
    // add r4,r3,r1 with r3 written the same cycle
    wb(5'd3, 32'h11);
    step(32'h8, rt_(5'd3, 5'd1, 5'd4, 6'h20), 1'b0, 1'b0, 32'h0,
         fe(32'h8, 32'h11, 32'd5, 32'h2020, 5'd3, 5'd1, 5'd4, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    // lw r3,0(r1) then dependent add: one stall cycle, one bubble
    step(32'hC, it_(6'h23, 5'd1, 5'd3, 16'h0), 1'b0, 1'b0, 32'h0,
         fe(32'hC, 32'd5, 32'h11, 32'h0, 5'd1, 5'd3, 5'd3, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1));
    step(32'h10, rt_(5'd3, 5'd1, 5'd4, 6'h20), 1'b1, 1'b0, 32'h0, bub_e());
    step(32'h10, rt_(5'd3, 5'd1, 5'd4, 6'h20), 1'b0, 1'b0, 32'h0,
         fe(32'h10, 32'h11, 32'd5, 32'h2020, 5'd3, 5'd1, 5'd4, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    // remaining R-type functs, sw, unsupported encodings
    wb(5'd5, 32'h99);
    step(32'h14, rt_(5'd1, 5'd3, 5'd5, 6'h22), 1'b0, 1'b0, 32'h0,
         fe(32'h14, 32'd5, 32'h11, 32'h2822, 5'd1, 5'd3, 5'd5, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1));
    step(32'h18, rt_(5'd1, 5'd3, 5'd6, 6'h24), 1'b0, 1'b0, 32'h0,
         fe(32'h18, 32'd5, 32'h11, 32'h3024, 5'd1, 5'd3, 5'd6, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1));
    step(32'h1C, rt_(5'd1, 5'd3, 5'd7, 6'h25), 1'b0, 1'b0, 32'h0,
         fe(32'h1C, 32'd5, 32'h11, 32'h3825, 5'd1, 5'd3, 5'd7, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1));
    step(32'h20, rt_(5'd1, 5'd3, 5'd8, 6'h2A), 1'b0, 1'b0, 32'h0,
         fe(32'h20, 32'd5, 32'h11, 32'h402A, 5'd1, 5'd3, 5'd8, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1));
    step(32'h24, it_(6'h2B, 5'd1, 5'd3, 16'hFFFC), 1'b0, 1'b0, 32'h0,
         fe(32'h24, 32'd5, 32'h11, 32'hFFFFFFFC, 5'd1, 5'd3, 5'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0));
    step(32'h28, it_(6'h3F, 5'd1, 5'd3, 16'h1234), 1'b0, 1'b0, 32'h0, nop_e());
    step(32'h2C, rt_(5'd1, 5'd3, 5'd9, 6'h21), 1'b0, 1'b0, 32'h0, nop_e());
    // branches and jumps
    step(32'h40, it_(6'h04, 5'd1, 5'd1, 16'hFFFE), 1'b0, 1'b1, 32'hFFFFFFF8, nop_e());
    step(32'h44, it_(6'h05, 5'd1, 5'd1, 16'h0005), 1'b0, 1'b0, 32'h0, nop_e());
    step(32'h48, it_(6'h05, 5'd1, 5'd3, 16'h0004), 1'b0, 1'b1, 32'h10, nop_e());
    step(32'h4C, it_(6'h04, 5'd1, 5'd3, 16'h0004), 1'b0, 1'b0, 32'h0, nop_e());
    step(32'h100, 32'h08000010, 1'b0, 1'b1, 32'hFFFFFF3C, nop_e());
    step(32'hF0000000, 32'h08000010, 1'b0, 1'b1, 32'h3C, nop_e());
    // bne r2,r0 while r2's ALU producer sits in EX/MEM
    exm(5'd2, 1'b0, 32'd7);
`ifdef DECODE_BRANCH_FWD_EN
    step(32'h200, it_(6'h05, 5'd2, 5'd0, 16'h0003), 1'b0, 1'b1, 32'hC, nop_e());
    wb(5'd2, 32'd7);
    step(32'h20C, 32'h0, 1'b0, 1'b0, 32'h0, nop_e());
`else
    step(32'h200, it_(6'h05, 5'd2, 5'd0, 16'h0003), 1'b1, 1'b0, 32'h0, bub_e());
    wb(5'd2, 32'd7);
    step(32'h200, it_(6'h05, 5'd2, 5'd0, 16'h0003), 1'b0, 1'b1, 32'hC, nop_e());
`endif
    // branch on an EX/MEM load always stalls
    exm(5'd2, 1'b1, 32'd9);
    step(32'h300, it_(6'h04, 5'd2, 5'd0, 16'h0001), 1'b1, 1'b0, 32'h0, bub_e());
    wb(5'd2, 32'd9);
    step(32'h300, it_(6'h04, 5'd2, 5'd0, 16'h0001), 1'b0, 1'b0, 32'h0, nop_e());
    // branch on ID/EX ALU result stalls; reset lands mid-stall
    step(32'h400, it_(6'h08, 5'd0, 5'd7, 16'h0001), 1'b0, 1'b0, 32'h0,
         fe(32'h400, 32'd0, 32'd0, 32'd1, 5'd0, 5'd7, 5'd7, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1));
    step(32'h404, it_(6'h04, 5'd7, 5'd0, 16'h0005), 1'b1, 1'b0, 32'h0, bub_e());
    @(negedge clk); #1;
    bus.instr_in = 32'h0;
    rst = 1'b1;
    #1;
    q_idex.delete();
    chk("mid_rst_idex_valid", 32'(bus.idex_valid), 32'h0);
    chk("mid_rst_idex_reg_write", 32'(bus.idex_reg_write), 32'h0);
    chk("mid_rst_idex_wreg", 32'(bus.idex_wreg), 32'h0);
    chk("mid_rst_idex_alu_src_imm", 32'(bus.idex_alu_src_imm), 32'h0);
    chk("mid_rst_idex_pc", bus.idex_pc, 32'h0);
    chk("mid_rst_idex_imm", bus.idex_imm, 32'h0);
    chk("mid_rst_stall_out", 32'(bus.stall_out), 32'h0);
    chk("mid_rst_jump_out", 32'(bus.jump_out), 32'h0);
    chk("mid_rst_offset_out", bus.offset_out, 32'h0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    // r5 and r1 were cleared by reset
    step(32'h500, rt_(5'd5, 5'd1, 5'd6, 6'h20), 1'b0, 1'b0, 32'h0,
         fe(32'h500, 32'd0, 32'd0, 32'h3020, 5'd5, 5'd1, 5'd6, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    step(32'h504, 32'h0, 1'b0, 1'b0, 32'h0, nop_e());

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(q_idex.size() + q_comb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
